// File: rtl/harpoon_shot_pkg.sv
// Shared game definitions for the harpoon projectile and its consumers
// (ball-collision logic, pixel mux).
//   GAME_FIRE_KEY  : HID keycode that launches a harpoon (space bar)
//   GAME_TOP_Y     : ceiling Y; no harpoon tip ever goes above it
//   SCREEN_W/H     : visible screen bounds in pixels
//   harpoon_state_t: harpoon FSM states, shared so collision logic can decode them
package harpoon_shot_pkg;

  localparam logic [7:0] GAME_FIRE_KEY = 8'h2C;
  localparam int         GAME_TOP_Y    = 10;
  localparam int         SCREEN_W      = 640;
  localparam int         SCREEN_H      = 480;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_RISE  = 2'd1,
    HS_STICK = 2'd2,
    HS_COOL  = 2'd3
  } harpoon_state_t;

endpackage

// File: rtl/harpoon_shot_if.sv
// Harpoon line report bus between the harpoon stage and the ball-collision logic.
//   HarpoonX       : left edge X of the harpoon line
//   HarpoonTipY    : current tip Y
//   HarpoonBaseY   : base Y, latched at launch
//   harpoon_active : harpoon is rising or stuck at the ceiling
//   ball_hit       : collision logic reports the harpoon touched a ball this frame
// master = harpoon stage, slave = collision logic.
interface harpoon_shot_if;
  import harpoon_shot_pkg::*;

  logic [9:0] HarpoonX;
  logic [9:0] HarpoonTipY;
  logic [9:0] HarpoonBaseY;
  logic       harpoon_active;
  logic       ball_hit;

  modport master (
    output HarpoonX, HarpoonTipY, HarpoonBaseY, harpoon_active,
    input  ball_hit
  );

  modport slave (
    input  HarpoonX, HarpoonTipY, HarpoonBaseY, harpoon_active,
    output ball_hit
  );

endinterface

// File: rtl/harpoon_shot_key_edge_detect.sv
// Fire-key edge detector.
// ORs the fire-key match across all four keyboard slots and produces a one-frame
// fire pulse on the frame where the key first appears. key_prev tracks the key
// every frame regardless of what the consumer is doing, so a key held through
// a whole shot never produces a late launch.
//   frame_clk : frame-rate clock
//   Reset     : asynchronous, active-low
//   keycode*  : current key slots
//   fire      : high for the single frame where the fire key becomes pressed
module key_edge_detect
  import harpoon_shot_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY = GAME_FIRE_KEY
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  output logic       fire
);

  logic key_now;
  logic key_prev;

  assign key_now = (keycode  == FIRE_KEY) || (keycode2 == FIRE_KEY) ||
                   (keycode3 == FIRE_KEY) || (keycode4 == FIRE_KEY);

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) key_prev <= 1'b0;
    else        key_prev <= key_now;
  end

  assign fire = key_now && !key_prev;

endmodule

// File: rtl/harpoon_shot.sv
// Harpoon projectile stage.
// Launches one vertical harpoon per fire-key press from the player's position,
// raises its tip SPEED pixels per frame until it reaches the ceiling, holds it
// there for HOLD_FRAMES frames, then blocks re-fire for COOL_FRAMES frames.
// A ball hit during flight/hold retracts it straight into the cooldown.
//   frame_clk, Reset          : frame clock, asynchronous active-low reset
//   keycode..keycode4         : keyboard slots
//   PlayerX/PlayerY/PlayerS   : player origin and height
//   game_on, collision        : game not running / player death force IDLE
//   DrawX, DrawY              : current VGA pixel
//   hbus (master)             : harpoon line report, ball_hit input
//   harpoon_on, Red/Green/Blue: per-pixel harpoon membership and colour
module harpoon_shot
  import harpoon_shot_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY    = GAME_FIRE_KEY,
  parameter int         SPEED       = 4,
  parameter int         TOP_Y       = GAME_TOP_Y,
  parameter int         HOLD_FRAMES = 30,
  parameter int         COOL_FRAMES = 8,
  parameter int         WIDTH       = 3,
  parameter int         X_OFFSET    = 21
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic [7:0]        keycode2,
  input  logic [7:0]        keycode3,
  input  logic [7:0]        keycode4,
  input  logic [9:0]        PlayerX,
  input  logic [9:0]        PlayerY,
  input  logic [9:0]        PlayerS,
  input  logic [1:0]        game_on,
  input  logic              collision,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  harpoon_shot_if.master    hbus,
  output logic              harpoon_on,
  output logic [3:0]        Red,
  output logic [3:0]        Green,
  output logic [3:0]        Blue
);

  localparam logic [9:0] TOP_Y_V      = 10'(TOP_Y);
  localparam logic [9:0] SPEED_V      = 10'(SPEED);
  localparam logic [9:0] RISE_LIMIT   = 10'(TOP_Y + SPEED);
  localparam logic [9:0] WIDTH_V      = 10'(WIDTH);
  localparam logic [9:0] X_OFFSET_V   = 10'(X_OFFSET);
  localparam logic [5:0] HOLD_LOAD    = 6'(HOLD_FRAMES - 1);
  localparam logic [5:0] COOL_LOAD    = 6'(COOL_FRAMES - 1);

  harpoon_state_t state;
  logic [5:0]     cnt;
  logic [9:0]     x_q;
  logic [9:0]     tip_q;
  logic [9:0]     base_q;
  logic           active_q;
  logic           fire;
  logic           force_idle;
  logic           in_flight;
  logic [9:0]     x_end;

  key_edge_detect #(
    .FIRE_KEY (FIRE_KEY)
  ) u_key_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .keycode2  (keycode2),
    .keycode3  (keycode3),
    .keycode4  (keycode4),
    .fire      (fire)
  );

  assign force_idle = (game_on == 2'd0) || collision;
  assign in_flight  = (state == HS_RISE) || (state == HS_STICK);

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state    <= HS_IDLE;
      cnt      <= 6'd0;
      x_q      <= 10'd0;
      tip_q    <= 10'd0;
      base_q   <= 10'd0;
      active_q <= 1'b0;
    end else if (force_idle) begin
      state    <= HS_IDLE;
      cnt      <= 6'd0;
      tip_q    <= base_q;
      active_q <= 1'b0;
    end else if (hbus.ball_hit && in_flight) begin
      // Retract the line immediately and go straight into the re-fire lockout.
      state    <= HS_COOL;
      cnt      <= COOL_LOAD;
      tip_q    <= base_q;
      active_q <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (fire) begin
            x_q      <= PlayerX + X_OFFSET_V;
            base_q   <= PlayerY + PlayerS;
            tip_q    <= PlayerY + PlayerS;
            active_q <= 1'b1;
            state    <= HS_RISE;
          end
        end
        HS_RISE: begin
          // Comparing before subtracting keeps the tip from overshooting the
          // ceiling and from ever wrapping below zero.
          if (tip_q <= RISE_LIMIT) begin
            tip_q <= TOP_Y_V;
            cnt   <= HOLD_LOAD;
            state <= HS_STICK;
          end else begin
            tip_q <= tip_q - SPEED_V;
          end
        end
        HS_STICK: begin
          if (cnt == 6'd0) begin
            cnt      <= COOL_LOAD;
            active_q <= 1'b0;
            state    <= HS_COOL;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        HS_COOL: begin
          if (cnt == 6'd0) state <= HS_IDLE;
          else             cnt   <= cnt - 6'd1;
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

  assign hbus.HarpoonX       = x_q;
  assign hbus.HarpoonTipY    = tip_q;
  assign hbus.HarpoonBaseY   = base_q;
  assign hbus.harpoon_active = active_q;

  assign x_end = x_q + WIDTH_V;

  always_comb begin
    harpoon_on = active_q &&
                 (DrawX >= x_q)   && (DrawX < x_end) &&
                 (DrawY >= tip_q) && (DrawY < base_q);
    Red   = harpoon_on ? 4'hC : 4'hF;
    Green = harpoon_on ? 4'hC : 4'hF;
    Blue  = harpoon_on ? 4'hC : 4'hF;
  end

endmodule

// File: tb/tb_harpoon_shot.sv
module tb_harpoon_shot;
  import harpoon_shot_pkg::*;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode, keycode2, keycode3, keycode4;
  logic [9:0] PlayerX, PlayerY, PlayerS;
  logic [1:0] game_on;
  logic       collision;
  logic [9:0] DrawX, DrawY;
  logic       harpoon_on;
  logic [3:0] Red, Green, Blue;

  int n_checks = 0;
  int n_fail   = 0;

  harpoon_shot_if hif ();

  harpoon_shot dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .keycode2   (keycode2),
    .keycode3   (keycode3),
    .keycode4   (keycode4),
    .PlayerX    (PlayerX),
    .PlayerY    (PlayerY),
    .PlayerS    (PlayerS),
    .game_on    (game_on),
    .collision  (collision),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hbus       (hif),
    .harpoon_on (harpoon_on),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},      32'(hif.HarpoonX),       32'd0);
    check({tag, "_tip"},    32'(hif.HarpoonTipY),    32'd0);
    check({tag, "_base"},   32'(hif.HarpoonBaseY),   32'd0);
    check({tag, "_active"}, 32'(hif.harpoon_active), 32'd0);
    check({tag, "_on"},     32'(harpoon_on),         32'd0);
    check({tag, "_rgb"},    {20'd0, Red, Green, Blue}, 32'hFFF);
  endtask

  task automatic press_space();
    keycode2 = 8'h2C;
  endtask

  task automatic release_space();
    keycode2 = 8'h00;
  endtask

  initial begin
    Reset = 1'b0;
    keycode = 8'h00; keycode2 = 8'h00; keycode3 = 8'h00; keycode4 = 8'h00;
    PlayerX = 10'd320; PlayerY = 10'd350; PlayerS = 10'd50;
    game_on = 2'd1; collision = 1'b0; hif.ball_hit = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    #2;
    check_reset_state("reset");
    #1 Reset = 1'b1;
    step(1);

    // Launch and first 10 frames of rise.
    press_space();
    step(1);
    check("launch_x",      32'(hif.HarpoonX),       32'd341);
    check("launch_base",   32'(hif.HarpoonBaseY),   32'd400);
    check("launch_tip",    32'(hif.HarpoonTipY),    32'd400);
    check("launch_active", 32'(hif.harpoon_active), 32'd1);
    PlayerX = 10'd100;
    step(10);
    check("rise10_tip",    32'(hif.HarpoonTipY),    32'd360);
    check("x_no_follow",   32'(hif.HarpoonX),       32'd341);

    // Draw window while tip = 300.
    step(15);
    check("rise25_tip", 32'(hif.HarpoonTipY), 32'd300);
    DrawX = 10'd342; DrawY = 10'd350; #1;
    check("draw_in_on",  32'(harpoon_on), 32'd1);
    check("draw_in_rgb", {20'd0, Red, Green, Blue}, 32'hCCC);
    DrawX = 10'd341; DrawY = 10'd300; #1;
    check("draw_corner_on", 32'(harpoon_on), 32'd1);
    DrawX = 10'd344; DrawY = 10'd350; #1;
    check("draw_right_off", 32'(harpoon_on), 32'd0);
    check("draw_right_rgb", {20'd0, Red, Green, Blue}, 32'hFFF);
    DrawX = 10'd342; DrawY = 10'd400; #1;
    check("draw_base_off", 32'(harpoon_on), 32'd0);
    DrawX = 10'd342; DrawY = 10'd299; #1;
    check("draw_above_off", 32'(harpoon_on), 32'd0);

    // Ceiling clamp: 98 rise edges in total from tip 400.
    step(72);
    check("pre_clamp_tip", 32'(hif.HarpoonTipY), 32'd12);
    step(1);
    check("clamp_tip",    32'(hif.HarpoonTipY),    32'd10);
    check("clamp_active", 32'(hif.harpoon_active), 32'd1);
    step(29);
    check("stick29_active", 32'(hif.harpoon_active), 32'd1);
    check("stick29_tip",    32'(hif.HarpoonTipY),    32'd10);
    step(1);
    check("stick_end_active", 32'(hif.harpoon_active), 32'd0);

    // Space still held through cooldown and beyond: no relaunch.
    step(20);
    check("held_no_refire", 32'(hif.harpoon_active), 32'd0);
    PlayerX = 10'd320;
    release_space();
    step(1);
    press_space();
    step(1);
    check("refire_active", 32'(hif.harpoon_active), 32'd1);
    check("refire_tip",    32'(hif.HarpoonTipY),    32'd400);

    // Ball hit at tip 200.
    step(50);
    check("hit_pre_tip", 32'(hif.HarpoonTipY), 32'd200);
    hif.ball_hit = 1'b1;
    step(1);
    hif.ball_hit = 1'b0;
    check("hit_active", 32'(hif.harpoon_active), 32'd0);
    check("hit_tip",    32'(hif.HarpoonTipY),    32'd400);
    release_space();
    step(1);
    press_space();
    step(1);
    check("cool_fire_ignored", 32'(hif.harpoon_active), 32'd0);
    release_space();
    step(10);
    press_space();
    step(1);
    check("post_cool_fire", 32'(hif.harpoon_active), 32'd1);

    // game_on = 0 during STICK.
    step(98 + 5);
    check("stick_again_tip",    32'(hif.HarpoonTipY),    32'd10);
    check("stick_again_active", 32'(hif.harpoon_active), 32'd1);
    game_on = 2'd0;
    step(1);
    game_on = 2'd1;
    check("gameoff_active", 32'(hif.harpoon_active), 32'd0);
    check("gameoff_tip",    32'(hif.HarpoonTipY),    32'd400);

    // Collision during RISE.
    release_space();
    step(1);
    press_space();
    step(3);
    check("coll_pre_tip", 32'(hif.HarpoonTipY), 32'd392);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    check("coll_active", 32'(hif.harpoon_active), 32'd0);
    check("coll_tip",    32'(hif.HarpoonTipY),    32'd400);

    // Asynchronous reset mid-RISE.
    release_space();
    step(1);
    press_space();
    step(4);
    check("prereset_active", 32'(hif.harpoon_active), 32'd1);
    DrawX = 10'd342; DrawY = 10'd395; #1;
    check("prereset_on", 32'(harpoon_on), 32'd1);
    Reset = 1'b0;
    #1;
    check_reset_state("async_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
